// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the byte-sequenced data-memory word port.
//   - state_t         : port FSM states
//   - BYTES_PER_WORD  : beats per word transfer
//   - LAST_BEAT       : beat-counter value of the final byte
//   - lane()          : big-endian byte lane for a beat (beat 0 -> bits 31:24)
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BEAT      = 2'(BYTES_PER_WORD - 1);

    // Beat 0 touches the lowest address, which holds the most significant byte.
    function automatic logic [1:0] lane(input logic [1:0] cnt);
        return 2'd3 - cnt;
    endfunction

endpackage

// File: rtl/dmem_word_port_byte_ram.sv
// -----------------------------------------------------------------------------
// byte_ram
//   Byte-wide RAM of 2**ADDR_W entries: synchronous write, asynchronous read.
//   Ports:
//     clk    - write clock
//     we     - write enable
//     waddr  - write byte address
//     wdata  - write byte
//     raddr  - read byte address
//     rdata  - read byte (combinational)
// -----------------------------------------------------------------------------
module byte_ram #(
    parameter int    ADDR_W    = 5,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(2**ADDR_W)-1];

    // NOTE: the array has no reset branch; contents survive rst_n and a reset
    // loop over every entry would turn the array into a wall of flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_word_port.sv
// -----------------------------------------------------------------------------
// dmem_word_port
//   32-bit word load/store port over a byte-wide RAM. Each accepted request
//   is serviced as four byte beats (big-endian, address wraps modulo RAM
//   size), followed by a one-cycle response. One word every 6 cycles.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     req_valid   - request present
//     req_ready   - port idle, request accepted on this edge if valid
//     req_we      - 1 = store word, 0 = load word
//     req_addr    - byte address of the most significant byte
//     req_wdata   - store data
//     rsp_valid   - one-cycle completion pulse
//     rsp_rdata   - assembled load data, held until the next load completes
//     misalign    - request address was not word aligned (informational)
//     busy        - transfer in progress
// -----------------------------------------------------------------------------
module dmem_word_port
    import dmem_pkg::*;
#(
    parameter int    ADDR_W    = 5,
    parameter string INIT_FILE = "initDm.dat"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              misalign,
    output logic              busy
);

    state_t            state;
    logic [1:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    // Upper three load bytes; the fourth comes straight from the RAM on the
    // last beat so rsp_rdata only changes when the response is issued.
    logic [23:0]       rdata_q;

    logic [ADDR_W-1:0] beat_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    // Address arithmetic is ADDR_W wide, so addr_q + cnt wraps naturally.
    assign beat_addr = addr_q + {{(ADDR_W-2){1'b0}}, cnt};
    assign ram_we    = (state == XFER) && we_q;
    assign ram_wdata = wdata_q[8*lane(cnt) +: 8];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    byte_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (beat_addr),
        .wdata (ram_wdata),
        .raddr (beat_addr),
        .rdata (ram_rdata)
    );

    // NOTE: all state here updates with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rdata_q   <= 24'd0;
            rsp_rdata <= 32'd0;
            misalign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        misalign <= |req_addr[1:0];
                        cnt      <= 2'd0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (!we_q) begin
                        case (cnt)
                            2'd0:    rdata_q[23:16] <= ram_rdata;
                            2'd1:    rdata_q[15:8]  <= ram_rdata;
                            2'd2:    rdata_q[7:0]   <= ram_rdata;
                            default: rsp_rdata      <= {rdata_q, ram_rdata};
                        endcase
                    end
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST_BEAT) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_word_port.sv
// -----------------------------------------------------------------------------
// tb_dmem_word_port
//   Directed bench for dmem_word_port: reset state, aligned and wrapping
//   word transfers, request held during a busy transfer, reset abort and
//   back-to-back loads.
// -----------------------------------------------------------------------------
module tb_dmem_word_port;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [4:0]  req_addr  = 5'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign;
    logic        busy;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] last_rd     = 32'd0;
    int          cyc         = 0;
    int          acc_cyc[$];

    always #5 clk = ~clk;

    dmem_word_port #(
        .ADDR_W    (5),
        .INIT_FILE ("")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .misalign  (misalign),
        .busy      (busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) acc_cyc.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // One complete word transfer, entered and left on a falling edge.
    task automatic txn(input string tag, input logic we, input logic [4:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_mis);
        int n;
        logic [31:0] want;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_wait: got %b want 1", tag, req_ready);
        end
        want      = we ? last_rd : exp_rd;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        // Scramble the request bus: only the accepted values may matter.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = addr + 5'd3;
        req_wdata = ~wdata;
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s xfer_cycle%0d: got rsp_valid=%b busy=%b want 0 1",
                         tag, k, rsp_valid, busy);
            end
            @(negedge clk);
        end
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s rsp_valid: got %b want 1", tag, rsp_valid);
        end
        vectors++;
        if (rsp_rdata !== want) begin
            miscompares++;
            $display("FAIL %s rsp_rdata: got %h want %h", tag, rsp_rdata, want);
        end
        vectors++;
        if (misalign !== exp_mis) begin
            miscompares++;
            $display("FAIL %s misalign: got %b want %b", tag, misalign, exp_mis);
        end
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ready_in_resp: got %b want 0", tag, req_ready);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_resp: got rsp_valid=%b ready=%b busy=%b want 0 1 0",
                     tag, rsp_valid, req_ready, busy);
        end
        vectors++;
        if (rsp_rdata !== want) begin
            miscompares++;
            $display("FAIL %s rdata_hold: got %h want %h", tag, rsp_rdata, want);
        end
        if (!we) last_rd = exp_rd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            misalign !== 1'b0 || rsp_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: got ready=%b rsp_valid=%b busy=%b mis=%b rdata=%h want 1 0 0 0 00000000",
                     req_ready, rsp_valid, busy, misalign, rsp_rdata);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        last_rd = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        txn("store_8", 1'b1, 5'd8, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("load_8",  1'b0, 5'd8, 32'h0, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_wrap();
        txn("store_30", 1'b1, 5'd30, 32'h11223344, 32'h0, 1'b1);
        txn("load_30",  1'b0, 5'd30, 32'h0, 32'h11223344, 1'b1);
    endtask

    task automatic test_hold_busy();
        int base;
        base = acc_cyc.size();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd8;
        req_wdata = 32'h0;
        @(negedge clk);
        // Load accepted; present a different store and keep it valid.
        req_we    = 1'b1;
        req_addr  = 5'd4;
        req_wdata = 32'hCAFEF00D;
        for (int i = 1; i <= 6; i++) begin
            vectors++;
            if (req_ready !== (i == 6)) begin
                miscompares++;
                $display("FAIL hold ready_cycle%0d: got %b want %b", i, req_ready, (i == 6));
            end
            if (i == 5) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
                    miscompares++;
                    $display("FAIL hold load_rsp: got valid=%b data=%h want 1 deadbeef",
                             rsp_valid, rsp_rdata);
                end
            end
            if (i < 6) @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i < 5) begin
                vectors++;
                if (rsp_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold store_early_rsp%0d: got %b want 0", i, rsp_valid);
                end
                @(negedge clk);
            end else begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
                    miscompares++;
                    $display("FAIL hold store_rsp: got valid=%b data=%h want 1 deadbeef",
                             rsp_valid, rsp_rdata);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (acc_cyc.size() - base !== 2) begin
            miscompares++;
            $display("FAIL hold accept_count: got %0d want 2", acc_cyc.size() - base);
        end
        last_rd = 32'hDEADBEEF;
        txn("load_4", 1'b0, 5'd4, 32'h0, 32'hCAFEF00D, 1'b0);
    endtask

    task automatic test_reset_abort();
        txn("clear_12", 1'b1, 5'd12, 32'h00000000, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'd12;
        req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
            rsp_rdata !== 32'd0 || misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: got busy=%b rsp_valid=%b ready=%b rdata=%h mis=%b want 0 0 1 00000000 0",
                     busy, rsp_valid, req_ready, rsp_rdata, misalign);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        last_rd = 32'd0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_rsp%0d: got rsp_valid=%b busy=%b want 0 0",
                         i, rsp_valid, busy);
            end
            @(negedge clk);
        end
        txn("load_12", 1'b0, 5'd12, 32'h0, 32'hAABB0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic        seen;
        logic [31:0] want;
        acc_cyc.delete();
        seen      = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd30;
        req_wdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
            want = seen ? 32'h11223344 : 32'hAABB0000;
            vectors++;
            if (rsp_rdata !== want) begin
                miscompares++;
                $display("FAIL b2b rdata_cycle%0d: got %h want %h", i, rsp_rdata, want);
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        vectors++;
        if (acc_cyc.size() !== 4) begin
            miscompares++;
            $display("FAIL b2b accept_count: got %0d want 4", acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            vectors++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
                miscompares++;
                $display("FAIL b2b spacing%0d: got %0d want 6", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_hold_busy();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
